// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches
// to imem and buffers {pc, instr} pairs in a small FIFO toward decode.
module fetch_unit #(
  parameter int unsigned        XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]      fifo_instr_q [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W-1:0] cnt_after_pop;

  // A redirect flushes the buffer, so nothing is reported as popped that cycle.
  assign pop           = (cnt_q != '0) && if_ready && !redirect_valid;
  assign cnt_after_pop = cnt_q - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    if (redirect_valid) begin
      unique case (state_q)
        S_REQ:   state_d = S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (cnt_after_pop < DEPTH_C) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            push = 1'b1;
            // Back-to-back issue only if the buffer still has room after this push.
            if (cnt_after_pop < DEPTH_M1_C) begin
              issue = 1'b1;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req  = reset && issue;
    imem_addr = pc_q;
    if_valid  = (cnt_q != '0);
    if_pc     = fifo_pc_q[rd_ptr_q];
    if_instr  = fifo_instr_q[rd_ptr_q];
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    cnt_d    = cnt_q - CNT_W'(pop) + CNT_W'(push);
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~XLEN'(3);
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (issue) begin
      pc_d     = pc_q + XLEN'(4);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
